// File: rtl/ps2_pkg.sv
// Shared constants, FSM encoding and frame-check helper for the PS/2 receiver.
package ps2_pkg;

    localparam int unsigned PS2_FRAME_BITS = 11;
    localparam logic [7:0]  PS2_BREAK      = 8'hF0;
    localparam logic [7:0]  PS2_EXT        = 8'hE0;

    typedef logic [1:0] ps2_state_t;

    localparam ps2_state_t StIdle  = 2'd0;
    localparam ps2_state_t StShift = 2'd1;
    localparam ps2_state_t StCheck = 2'd2;

    // Frame layout after 11 LSB-first shifts: [0]=start, [8:1]=data, [9]=parity, [10]=stop.
    function automatic logic frame_ok(input logic [PS2_FRAME_BITS-1:0] fr,
                                      input logic                      par_en);
        return ~fr[0] & fr[10] & (~par_en | (^fr[9:1]));
    endfunction

endpackage

// File: rtl/ps2_filter.sv
// Input conditioning for the PS/2 pins: 2-FF synchronisers on both lines and a
// FILTER_LEN-sample debounce on the clock line, producing a one-cycle fall pulse.
module ps2_filter #(
    parameter int unsigned FILTER_LEN = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ps2c_i,
    input  logic ps2d_i,
    output logic fall_o,
    output logic data_o
);

    localparam int unsigned CntW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    logic [1:0]      c_sync_q;
    logic [1:0]      d_sync_q;
    logic            filt_q, filt_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            fall;

    // Counts consecutive samples that disagree with the accepted level.
    always_comb begin
        filt_d = filt_q;
        cnt_d  = '0;
        fall   = 1'b0;
        if (c_sync_q[1] != filt_q) begin
            if (cnt_q == CntW'(FILTER_LEN - 1)) begin
                filt_d = c_sync_q[1];
                fall   = filt_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_sync_q <= 2'b11;
            d_sync_q <= 2'b11;
            filt_q   <= 1'b1;
            cnt_q    <= '0;
        end else begin
            c_sync_q <= {c_sync_q[0], ps2c_i};
            d_sync_q <= {d_sync_q[0], ps2d_i};
            filt_q   <= filt_d;
            cnt_q    <= cnt_d;
        end
    end

    assign fall_o = fall;
    assign data_o = d_sync_q[1];

endmodule

// File: rtl/ps2_sync.sv
// PS/2 device-to-host receiver: frame FSM, shift register, timeout and output registers.
// Define PS2_PARITY_CHECK_EN to reject frames with bad odd parity.
module ps2_sync
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2c,
    input  logic       ps2d,
    output logic [7:0] dout,
    output logic [7:0] pout,
    output logic       ready
);

    localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);

`ifdef PS2_PARITY_CHECK_EN
    localparam logic ParEn = 1'b1;
`else
    localparam logic ParEn = 1'b0;
`endif

    logic                      fall;
    logic                      data_s;
    ps2_state_t                state_q, state_d;
    logic [3:0]                bitcnt_q, bitcnt_d;
    logic [PS2_FRAME_BITS-1:0] sr_q, sr_d, sr_shift;
    logic [TmoW-1:0]           tmo_q, tmo_d;
    logic [7:0]                dout_q, dout_d;
    logic [7:0]                pout_q, pout_d;
    logic                      ready_q, ready_d;

    ps2_filter #(
        .FILTER_LEN(FILTER_LEN)
    ) u_filter (
        .clk   (clk),
        .rst_n (rst_n),
        .ps2c_i(ps2c),
        .ps2d_i(ps2d),
        .fall_o(fall),
        .data_o(data_s)
    );

    assign sr_shift = {data_s, sr_q[PS2_FRAME_BITS-1:1]};

    always_comb begin
        state_d  = state_q;
        bitcnt_d = bitcnt_q;
        sr_d     = sr_q;
        tmo_d    = '0;
        dout_d   = dout_q;
        pout_d   = pout_q;
        ready_d  = 1'b0;
        case (state_q)
            StIdle: begin
                if (fall && !data_s) begin
                    state_d  = StShift;
                    bitcnt_d = 4'd0;
                    sr_d     = sr_shift;
                end
            end
            StShift: begin
                if (fall) begin
                    sr_d     = sr_shift;
                    bitcnt_d = bitcnt_q + 4'd1;
                    // bitcnt counts bits after the start bit; the 10th is the stop bit.
                    if (bitcnt_q == 4'd9) begin
                        state_d = StCheck;
                    end
                end else if (tmo_q == TmoW'(TIMEOUT_CYCLES)) begin
                    state_d = StIdle;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            StCheck: begin
                if (frame_ok(sr_q, ParEn)) begin
                    ready_d = 1'b1;
                    pout_d  = dout_q;
                    dout_d  = sr_q[8:1];
                end
                // A start edge landing here begins the next frame directly.
                if (fall && !data_s) begin
                    state_d  = StShift;
                    bitcnt_d = 4'd0;
                    sr_d     = sr_shift;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            bitcnt_q <= 4'd0;
            sr_q     <= '0;
            tmo_q    <= '0;
            dout_q   <= 8'h00;
            pout_q   <= 8'h00;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            bitcnt_q <= bitcnt_d;
            sr_q     <= sr_d;
            tmo_q    <= tmo_d;
            dout_q   <= dout_d;
            pout_q   <= pout_d;
            ready_q  <= ready_d;
        end
    end

    assign dout  = dout_q;
    assign pout  = pout_q;
    assign ready = ready_q;

endmodule

// File: tb/tb_ps2_sync.sv
// Self-checking bench for ps2_sync: directed scenarios plus randomized frames
// checked against a byte-level queue model.
module tb_ps2_sync;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       ps2c  = 1'b1;
    logic       ps2d  = 1'b1;
    logic [7:0] dout;
    logic [7:0] pout;
    logic       ready;

`ifdef PS2_PARITY_CHECK_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    always #5 clk = ~clk;

    ps2_sync #(
        .FILTER_LEN    (4),
        .TIMEOUT_CYCLES(255)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .ps2c (ps2c),
        .ps2d (ps2d),
        .dout (dout),
        .pout (pout),
        .ready(ready)
    );

    int          n_cmp   = 0;
    int          n_err   = 0;
    int          n_ready = 0;
    logic [15:0] exp_q[$];
    logic [7:0]  m_dout  = 8'h00;
    logic [7:0]  m_pout  = 8'h00;
    logic        ready_prev = 1'b0;

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Model: a byte is accepted iff start=0, stop=1 and (optionally) odd parity holds.
    task automatic model_frame(input logic [10:0] fr);
        bit valid;
        valid = !fr[0] && fr[10] && (!PAR_EN || (^fr[9:1]));
        if (valid) begin
            exp_q.push_back({fr[8:1], m_dout});
            m_pout = m_dout;
            m_dout = fr[8:1];
        end
    endtask

    task automatic send_frame(input logic [7:0] data, input bit bad_par, input bit bad_stop,
                              input int nbits, input int hp, input bit glitch);
        logic [10:0] fr;
        fr = {~bad_stop, (~^data) ^ bad_par, data, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2d = fr[i];
            wait_clk(hp / 2);
            ps2c = 1'b0;
            if (i == 10) model_frame(fr);
            wait_clk(hp);
            ps2c = 1'b1;
            wait_clk(hp - hp / 2);
            if (glitch && i == 5) begin
                wait_clk(4);
                ps2c = 1'b0;
                wait_clk(2);
                ps2c = 1'b1;
                wait_clk(4);
            end
        end
        ps2d = 1'b1;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 60) begin
            wait_clk(1);
            k++;
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL ready_timeout: got %0d pending bytes expected 0", exp_q.size());
            exp_q.delete();
        end
        wait_clk(8);
    endtask

    // Per-cycle compare of DUT outputs against the model.
    always @(negedge clk) begin
        logic [15:0] e;
        if (rst_n) begin
            if (ready) begin
                n_ready++;
                chk8("ready_width", {7'b0, ready_prev}, 8'h00);
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL ready_unexpected: got ready=1 dout=%h expected no pulse", dout);
                end else begin
                    e = exp_q.pop_front();
                    chk8("dout_on_ready", dout, e[15:8]);
                    chk8("pout_on_ready", pout, e[7:0]);
                end
            end else if (exp_q.size() == 0) begin
                chk8("dout_hold", dout, m_dout);
                chk8("pout_hold", pout, m_pout);
            end
        end
        ready_prev <= ready;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got no finish expected finish within 2ms");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0;
        int hp;
        int nb;
        logic [7:0] b;

        wait_clk(3);
        chk8("reset_dout", dout, 8'h00);
        chk8("reset_pout", pout, 8'h00);
        chk8("reset_ready", {7'b0, ready}, 8'h00);
        rst_n = 1'b1;
        wait_clk(5);

        r0 = n_ready;
        send_frame(8'h1D, 0, 0, 11, 10, 0);
        wait_idle();
        chk8("t1_dout", dout, 8'h1D);
        chk8("t1_pout", pout, 8'h00);
        chk8("t1_pulses", 8'(n_ready - r0), 8'd1);

        r0 = n_ready;
        send_frame(8'hF0, 0, 0, 11, 10, 0);
        wait_idle();
        send_frame(8'h1D, 0, 0, 11, 10, 0);
        wait_idle();
        chk8("t2_dout", dout, 8'h1D);
        chk8("t2_pout", pout, 8'hF0);
        chk8("t2_pulses", 8'(n_ready - r0), 8'd2);

        r0 = n_ready;
        send_frame(8'h1C, 0, 1, 11, 10, 0);
        wait_idle();
        chk8("t3_dout", dout, 8'h1D);
        chk8("t3_pout", pout, 8'hF0);
        chk8("t3_pulses", 8'(n_ready - r0), 8'd0);

        send_frame(8'h23, 1, 0, 11, 10, 0);
        wait_idle();
`ifdef PS2_PARITY_CHECK_EN
        chk8("t4_dout", dout, 8'h1D);
        chk8("t4_pout", pout, 8'hF0);
`else
        chk8("t4_dout", dout, 8'h23);
        chk8("t4_pout", pout, 8'h1D);
`endif

        send_frame(8'h55, 0, 0, 5, 10, 0);
        wait_clk(300);
        send_frame(8'h29, 0, 0, 11, 10, 0);
        wait_idle();
        chk8("t5_dout", dout, 8'h29);

        send_frame(8'hB6, 0, 0, 11, 10, 1);
        wait_idle();
        chk8("glitch_dout", dout, 8'hB6);
        chk8("glitch_pout", pout, 8'h29);

        for (int n = 0; n < 40; n++) begin
            b  = 8'($urandom);
            hp = $urandom_range(8, 14);
            if ($urandom_range(0, 9) == 0) begin
                nb = $urandom_range(1, 10);
                send_frame(b, 0, 0, nb, hp, 0);
                wait_clk(280);
            end else begin
                send_frame(b, $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0, 11, hp,
                           $urandom_range(0, 4) == 0);
                wait_idle();
            end
            wait_clk($urandom_range(0, 20));
        end

        send_frame(8'hC3, 0, 0, 4, 10, 1);
        #3;
        rst_n = 1'b0;
        #1;
        chk8("t6_reset_dout", dout, 8'h00);
        chk8("t6_reset_pout", pout, 8'h00);
        chk8("t6_reset_ready", {7'b0, ready}, 8'h00);
        exp_q.delete();
        m_dout = 8'h00;
        m_pout = 8'h00;
        wait_clk(4);
        rst_n = 1'b1;
        wait_clk(4);
        send_frame(8'h5A, 0, 0, 11, 10, 0);
        wait_idle();
        chk8("t6_after_dout", dout, 8'h5A);
        chk8("t6_after_pout", pout, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
